// File: rtl/triangle_feeder.sv
// Triangle list producer: reads three vertex words per triangle from mesh memory,
// translates and clamps them to the viewport, and hands them to the rasterizer.
//
// state   | meaning
// IDLE    | waiting for new_frame; mem_addr parked at 0
// FETCH   | issuing the three vertex addresses of tri_idx (f = 0,1,2)
// WAIT    | draining read latency until vertex 3 is captured
// PRESENT | triangle valid on vert1..3, held until ready_in
// DONE    | one-cycle frame_done pulse
module triangle_feeder #(
  parameter int WIDTH        = 240,
  parameter int HEIGHT       = 240,
  parameter int ADDR_W       = 12,
  parameter int TRI_W        = 10,
  parameter int BASE_ADDR    = 0,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              new_frame,
  input  logic [TRI_W-1:0]  num_tris,
  input  logic [9:0]        x_offset,
  input  logic [9:0]        y_offset,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [26:0]       mem_data,
  input  logic              ready_in,
  output logic [2:0][8:0]   vert1,
  output logic [2:0][8:0]   vert2,
  output logic [2:0][8:0]   vert3,
  output logic              valid_tri,
  output logic              obj_done,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic signed [10:0] X_MAX  = 11'(WIDTH - 1);
  localparam logic signed [10:0] Y_MAX  = 11'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0]  BASE_A = ADDR_W'(BASE_ADDR);

  logic [2:0]        state_q, state_d;
  logic [TRI_W-1:0]  tri_idx_q, tri_idx_d;
  logic [TRI_W-1:0]  num_q;
  logic [9:0]        xoff_q, yoff_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        fcnt_q, fcnt_d;
  logic [READ_LATENCY-1:0]      pipe_v_q;
  logic [READ_LATENCY-1:0][1:0] pipe_tag_q;
  logic [2:0][8:0]   v1_q, v2_q, v3_q;

  logic              cap_v;
  logic [1:0]        cap_tag;
  logic              last_cap;
  logic              is_last;
  logic [TRI_W-1:0]  nxt_idx;
  logic [ADDR_W-1:0] nxt_idx_a;
  logic [ADDR_W-1:0] nxt_addr;
  logic [2:0][8:0]   xf_word;

  // 11-bit signed add of an unsigned coordinate and a signed offset, clamped to [0, max_v]
  function automatic logic [8:0] clamp_add(input logic [8:0] v, input logic [9:0] off,
                                           input logic signed [10:0] max_v);
    logic signed [10:0] s;
    s = $signed({2'b00, v}) + $signed({off[9], off});
    if (s < 11'sd0) return 9'd0;
    if (s > max_v) return max_v[8:0];
    return s[8:0];
  endfunction

  assign cap_v     = pipe_v_q[READ_LATENCY-1];
  assign cap_tag   = pipe_tag_q[READ_LATENCY-1];
  assign last_cap  = cap_v && (cap_tag == 2'd2);
  assign is_last   = (tri_idx_q == num_q - TRI_W'(1));
  assign nxt_idx   = tri_idx_q + TRI_W'(1);
  assign nxt_idx_a = ADDR_W'(nxt_idx);
  assign nxt_addr  = BASE_A + (nxt_idx_a << 1) + nxt_idx_a;
  assign xf_word   = {clamp_add(mem_data[26:18], xoff_q, X_MAX),
                      clamp_add(mem_data[17:9], yoff_q, Y_MAX),
                      mem_data[8:0]};

  always_comb begin
    state_d   = state_q;
    tri_idx_d = tri_idx_q;
    addr_d    = addr_q;
    fcnt_d    = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (new_frame) begin
          tri_idx_d = '0;
          if (num_tris == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            addr_d  = BASE_A;
            fcnt_d  = 2'd0;
          end
        end
      end
      S_FETCH: begin
        if (fcnt_q == 2'd2) begin
          state_d = S_WAIT;
        end else begin
          fcnt_d = fcnt_q + 2'd1;
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_WAIT: begin
        if (last_cap) state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (ready_in) begin
          if (is_last) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_FETCH;
            tri_idx_d = nxt_idx;
            addr_d    = nxt_addr;
            fcnt_d    = 2'd0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      tri_idx_q  <= '0;
      num_q      <= '0;
      xoff_q     <= '0;
      yoff_q     <= '0;
      addr_q     <= '0;
      fcnt_q     <= 2'd0;
      pipe_v_q   <= '0;
      pipe_tag_q <= '0;
      v1_q       <= '0;
      v2_q       <= '0;
      v3_q       <= '0;
    end else begin
      state_q   <= state_d;
      tri_idx_q <= tri_idx_d;
      addr_q    <= addr_d;
      fcnt_q    <= fcnt_d;
      if (state_q == S_IDLE && new_frame) begin
        num_q  <= num_tris;
        xoff_q <= x_offset;
        yoff_q <= y_offset;
      end
      // Tag each issued address with its vertex slot and age it by the read latency
      pipe_v_q[0]   <= (state_q == S_FETCH);
      pipe_tag_q[0] <= fcnt_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v_q[i]   <= pipe_v_q[i-1];
        pipe_tag_q[i] <= pipe_tag_q[i-1];
      end
      if (cap_v) begin
        case (cap_tag)
          2'd0:    v1_q <= xf_word;
          2'd1:    v2_q <= xf_word;
          default: v3_q <= xf_word;
        endcase
      end
    end
  end

  assign mem_addr   = addr_q;
  assign vert1      = v1_q;
  assign vert2      = v2_q;
  assign vert3      = v3_q;
  assign valid_tri  = (state_q == S_PRESENT);
  assign obj_done   = valid_tri && is_last;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_triangle_feeder.sv
// Bench for triangle_feeder: three instances (read latency 2, 1, 4) share one mesh memory
// image and stimulus; a per-frame reference list is compared by a monitor at each transfer.
module tb_triangle_feeder;

  localparam int AW = 12;
  localparam int TW = 10;
  localparam int W  = 240;
  localparam int H  = 240;
  localparam int ND = 3;

  typedef struct packed {
    logic [2:0][8:0] a;
    logic [2:0][8:0] b;
    logic [2:0][8:0] c;
    logic            last;
  } tri_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          new_frame;
  logic [TW-1:0] num_tris;
  logic [9:0]    x_off, y_off;

  logic            ready [ND];
  logic [AW-1:0]   addr  [ND];
  logic [26:0]     mdata [ND];
  logic [2:0][8:0] v1 [ND];
  logic [2:0][8:0] v2 [ND];
  logic [2:0][8:0] v3 [ND];
  logic            valid [ND];
  logic            objd  [ND];
  logic            busy  [ND];
  logic            fdone [ND];

  logic [26:0] mem [0:4095];
  logic [26:0] p0 [2];
  logic [26:0] p1 [1];
  logic [26:0] p2 [4];

  tri_t exp_q[$];
  int   rd_idx [ND];
  int   checks = 0;
  int   errors = 0;
  int   frames_exp = 0;
  int   mode = 0;
  bit   mon_en = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;

  triangle_feeder #(.READ_LATENCY(2)) dut0 (
    .clk_in(clk), .rst_in(rst_n), .new_frame(new_frame), .num_tris(num_tris),
    .x_offset(x_off), .y_offset(y_off), .mem_addr(addr[0]), .mem_data(mdata[0]),
    .ready_in(ready[0]), .vert1(v1[0]), .vert2(v2[0]), .vert3(v3[0]),
    .valid_tri(valid[0]), .obj_done(objd[0]), .busy(busy[0]), .frame_done(fdone[0]));

  triangle_feeder #(.READ_LATENCY(1)) dut1 (
    .clk_in(clk), .rst_in(rst_n), .new_frame(new_frame), .num_tris(num_tris),
    .x_offset(x_off), .y_offset(y_off), .mem_addr(addr[1]), .mem_data(mdata[1]),
    .ready_in(ready[1]), .vert1(v1[1]), .vert2(v2[1]), .vert3(v3[1]),
    .valid_tri(valid[1]), .obj_done(objd[1]), .busy(busy[1]), .frame_done(fdone[1]));

  triangle_feeder #(.READ_LATENCY(4)) dut2 (
    .clk_in(clk), .rst_in(rst_n), .new_frame(new_frame), .num_tris(num_tris),
    .x_offset(x_off), .y_offset(y_off), .mem_addr(addr[2]), .mem_data(mdata[2]),
    .ready_in(ready[2]), .vert1(v1[2]), .vert2(v2[2]), .vert3(v3[2]),
    .valid_tri(valid[2]), .obj_done(objd[2]), .busy(busy[2]), .frame_done(fdone[2]));

  // Mesh memory with a per-instance read pipeline of the matching latency
  always @(posedge clk) begin
    p0[0] <= mem[addr[0]];
    p0[1] <= p0[0];
    p1[0] <= mem[addr[1]];
    p2[0] <= mem[addr[2]];
    p2[1] <= p2[0];
    p2[2] <= p2[1];
    p2[3] <= p2[2];
  end
  assign mdata[0] = p0[1];
  assign mdata[1] = p1[0];
  assign mdata[2] = p2[3];

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  function automatic logic [26:0] word(input int x, input int y, input int z);
    return {9'(x), 9'(y), 9'(z)};
  endfunction

  function automatic logic [8:0] clampv(input int v, input int off, input int lim);
    int s;
    s = v + off;
    if (s < 0) s = 0;
    if (s > lim) s = lim;
    return 9'(s);
  endfunction

  function automatic logic [2:0][8:0] model_vert(input logic [26:0] w, input int xo, input int yo);
    return {clampv(int'(w[26:18]), xo, W - 1), clampv(int'(w[17:9]), yo, H - 1), w[8:0]};
  endfunction

  task automatic check(input string name, input int d, input logic [81:0] got,
                       input logic [81:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h want %0h (t=%0t)", name, d, got, want, $time);
    end
  endtask

  task automatic fill_rand(input int nwords);
    for (int i = 0; i < nwords; i++) mem[i] = 27'($urandom);
  endtask

  // Called at a negedge; the frame's expected triangles are queued before the DUT can show any
  task automatic start_frame(input int n, input int xo, input int yo);
    tri_t e;
    for (int t = 0; t < n; t++) begin
      e.a    = model_vert(mem[(3 * t) % 4096], xo, yo);
      e.b    = model_vert(mem[(3 * t + 1) % 4096], xo, yo);
      e.c    = model_vert(mem[(3 * t + 2) % 4096], xo, yo);
      e.last = (t == n - 1);
      exp_q.push_back(e);
    end
    frames_exp++;
    new_frame = 1'b1;
    num_tris  = TW'(n);
    x_off     = 10'(xo);
    y_off     = 10'(yo);
    @(negedge clk);
    new_frame = 1'b0;
  endtask

  function automatic bit any_busy();
    bit b;
    b = 1'b0;
    for (int d = 0; d < ND; d++) b |= busy[d];
    return b;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (any_busy() && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout after %0d cycles, required all idle", n);
    end
    for (int d = 0; d < ND; d++) begin
      check("transfers", d, 82'(rd_idx[d]), 82'(exp_q.size()));
      check("idle_addr", d, 82'(addr[d]), 82'd0);
    end
    exp_q.delete();
    for (int d = 0; d < ND; d++) rd_idx[d] = 0;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: drives each instance's ready, checks handshake rules and pops expected triangles
  bit  prev_valid [ND];
  bit  prev_ready [ND];
  bit  prev_busy  [ND];
  bit  prev_fdone [ND];
  bit  xfer_pend  [ND];
  bit  last_pend  [ND];
  int  fetch_start[ND];
  int  stall      [ND];
  int  fd_cnt     [ND];
  logic [2:0][8:0] pv1 [ND];
  logic [2:0][8:0] pv2 [ND];
  logic [2:0][8:0] pv3 [ND];

  initial begin
    tri_t e;
    for (int d = 0; d < ND; d++) begin
      ready[d] = 1'b1; prev_valid[d] = 0; prev_ready[d] = 0; prev_busy[d] = 0;
      prev_fdone[d] = 0; xfer_pend[d] = 0; last_pend[d] = 0; fetch_start[d] = 0;
      stall[d] = 0; fd_cnt[d] = 0; rd_idx[d] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        for (int d = 0; d < ND; d++) begin
          if (xfer_pend[d]) begin
            check("valid_after_xfer", d, 82'(valid[d]), 82'd0);
            if (last_pend[d]) check("frame_done_after_last", d, 82'(fdone[d]), 82'd1);
            else fetch_start[d] = cyc;
          end else if (busy[d] && !prev_busy[d]) begin
            fetch_start[d] = cyc;
          end
          if (prev_valid[d] && !prev_ready[d])
            check("stall_hold", d, {valid[d], v1[d], v2[d], v3[d]}, {1'b1, pv1[d], pv2[d], pv3[d]});
          if (valid[d] && !prev_valid[d])
            check("valid_latency", d, 82'(cyc - fetch_start[d]), 82'(3 + lat_of(d)));
          if (fdone[d]) begin
            fd_cnt[d]++;
            check("frame_done_width", d, 82'(prev_fdone[d]), 82'd0);
          end
          case (mode)
            0:       ready[d] = 1'b1;
            1:       ready[d] = ($urandom_range(0, 3) != 0);
            default: ready[d] = valid[d] && (stall[d] >= 20);
          endcase
          if (valid[d] && !ready[d]) stall[d]++;
          xfer_pend[d] = 1'b0;
          last_pend[d] = 1'b0;
          if (valid[d] && ready[d]) begin
            xfer_pend[d] = 1'b1;
            stall[d] = 0;
            if (rd_idx[d] >= exp_q.size()) begin
              check("unexpected_xfer", d, 82'(rd_idx[d]), 82'(exp_q.size() - 1));
            end else begin
              e = exp_q[rd_idx[d]];
              rd_idx[d]++;
              check("triangle", d, {v1[d], v2[d], v3[d], objd[d]}, e);
              last_pend[d] = e.last;
            end
          end
          prev_valid[d] = valid[d];
          prev_ready[d] = ready[d];
          prev_busy[d]  = busy[d];
          prev_fdone[d] = fdone[d];
          pv1[d] = v1[d];
          pv2[d] = v2[d];
          pv3[d] = v3[d];
        end
      end
    end
  end

  initial begin
    int n, xo, yo;
    rst_n = 1'b0;
    new_frame = 1'b0;
    num_tris = '0;
    x_off = '0;
    y_off = '0;
    fill_rand(4096);
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check("rst_valid", d, 82'(valid[d]), 82'd0);
      check("rst_obj_done", d, 82'(objd[d]), 82'd0);
      check("rst_busy", d, 82'(busy[d]), 82'd0);
      check("rst_frame_done", d, 82'(fdone[d]), 82'd0);
      check("rst_verts", d, {v1[d], v2[d], v3[d]}, 82'd0);
      check("rst_addr", d, 82'(addr[d]), 82'd0);
    end
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Basic single triangle, no offset
    mem[0] = word(10, 20, 5);
    mem[1] = word(50, 20, 7);
    mem[2] = word(30, 60, 3);
    mode = 0;
    start_frame(1, 0, 0);
    wait_idle();

    // Back-pressure: 20-cycle stall at every presentation
    fill_rand(9);
    mode = 2;
    start_frame(3, 3, -4);
    wait_idle();
    mode = 0;

    // Clamping at both ends of the viewport
    mem[0] = word(5, 15, 9);
    mem[1] = word(235, 0, 77);
    mem[2] = word(100, 100, 511);
    start_frame(1, -20, 230);
    wait_idle();
    start_frame(1, 10, 0);
    wait_idle();

    // Zero triangles: DONE directly, address never leaves 0
    start_frame(0, 5, 5);
    for (int d = 0; d < ND; d++) begin
      check("zero_frame_done", d, 82'(fdone[d]), 82'd1);
      check("zero_valid", d, 82'(valid[d]), 82'd0);
      check("zero_addr", d, 82'(addr[d]), 82'd0);
    end
    wait_idle();

    // new_frame during PRESENT must not restart the frame
    fill_rand(6);
    start_frame(2, 1, 2);
    n = 0;
    while (!valid[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_present timeout after %0d cycles, required valid_tri", n);
    end
    new_frame = 1'b1;
    num_tris  = TW'(5);
    x_off     = 10'd100;
    @(negedge clk);
    new_frame = 1'b0;
    wait_idle();

    // Reset while in WAIT aborts the frame
    fill_rand(6);
    start_frame(2, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < ND; d++) begin
      check("abort_valid", d, 82'(valid[d]), 82'd0);
      check("abort_busy", d, 82'(busy[d]), 82'd0);
      check("abort_addr", d, 82'(addr[d]), 82'd0);
    end
    exp_q.delete();
    for (int d = 0; d < ND; d++) rd_idx[d] = 0;
    frames_exp--;
    repeat (5) @(negedge clk);
    fill_rand(3);
    start_frame(1, -7, 9);
    wait_idle();

    // Randomized frames with random back-pressure
    mode = 1;
    for (int f = 0; f < 8; f++) begin
      n  = $urandom_range(1, 6);
      xo = $urandom_range(0, 1023);
      yo = $urandom_range(0, 1023);
      if (xo > 511) xo -= 1024;
      if (yo > 511) yo -= 1024;
      fill_rand(3 * n);
      start_frame(n, xo, yo);
      wait_idle();
    end
    mode = 0;

    for (int d = 0; d < ND; d++) check("frame_done_count", d, 82'(fd_cnt[d]), 82'(frames_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
